// File: rtl/pe_mem_responder_if.sv
// Bundle between pe_mem_responder, the system, the PE and the two SRAMs.
// master = system/PE/SRAM side, slave = responder.
interface pe_mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 32,
  parameter int IN_AW  = 8,
  parameter int OUT_AW = 6
);
  logic              go;
  logic              pe_start;
  logic              pe_buf_load;
  logic [DATA_W-1:0] pe_data;
  logic              pe_store;
  logic [RES_W-1:0]  pe_res;
  logic              pe_done;
  logic              rd_en;
  logic [IN_AW-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [OUT_AW-1:0] wr_addr;
  logic [RES_W-1:0]  wr_data;
  logic              busy;
  logic              all_done;
  logic              err;

  modport master (
    output go, pe_buf_load, pe_store, pe_res, pe_done, rd_data,
    input  pe_start, pe_data, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           busy, all_done, err
  );

  modport slave (
    input  go, pe_buf_load, pe_store, pe_res, pe_done, rd_data,
    output pe_start, pe_data, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           busy, all_done, err
  );
endinterface

// File: rtl/pe_mem_responder.sv
// Memory-side responder for the conv PE: prefetches input words, streams them on
// load requests, writes results on store requests. Optional: STORE_CHECKSUM_EN.
module pe_mem_responder #(
  parameter int DATA_W    = 8,
  parameter int RES_W     = 32,
  parameter int IN_AW     = 8,
  parameter int OUT_AW    = 6,
  parameter int OUT_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  pe_mem_responder_if.slave bus
`ifdef STORE_CHECKSUM_EN
  ,
  output logic [RES_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_ARM, S_RUN, S_DONE} state_t;

  // One extra bit so the write counter can hold OUT_DEPTH even when it equals 2^OUT_AW.
  localparam logic [OUT_AW:0] WR_LIMIT = (OUT_AW + 1)'(OUT_DEPTH);

  state_t            state_q, state_d;
  logic [IN_AW-1:0]  rd_addr_q;
  logic [OUT_AW:0]   wr_cnt_q;
  logic [DATA_W-1:0] pf_q;
  logic              pf_valid_q;
  logic              rd_pending_q;
  logic              load_seen_q;
  logic              err_q;

  logic              run_start;
  logic              rd_en;
  logic              do_load;
  logic              wr_en;
  logic              wr_ovf;
  logic [RES_W-1:0]  wr_data;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    rd_en     = 1'b0;
    do_load   = 1'b0;
    wr_en     = 1'b0;
    wr_ovf    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          state_d   = S_PREFETCH;
          run_start = 1'b1;
        end
      end
      S_PREFETCH: begin
        rd_en   = 1'b1;
        state_d = S_ARM;
      end
      S_ARM: state_d = S_RUN;
      S_RUN: begin
        do_load = bus.pe_buf_load;
        rd_en   = bus.pe_buf_load;
        if (bus.pe_store) begin
          if (wr_cnt_q != WR_LIMIT) wr_en  = 1'b1;
          else                      wr_ovf = 1'b1;
        end
        if (bus.pe_done) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q    <= '0;
      wr_cnt_q     <= '0;
      pf_q         <= '0;
      pf_valid_q   <= 1'b0;
      rd_pending_q <= 1'b0;
      load_seen_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rd_pending_q <= rd_en;
      if (rd_pending_q) pf_q <= bus.rd_data;
      if (run_start) begin
        rd_addr_q   <= '0;
        wr_cnt_q    <= '0;
        pf_valid_q  <= 1'b0;
        load_seen_q <= 1'b0;
        err_q       <= 1'b0;
      end
      if (state_q == S_ARM) begin
        pf_valid_q <= 1'b1;
        rd_addr_q  <= IN_AW'(1);
      end
      if (do_load) begin
        rd_addr_q   <= rd_addr_q + 1'b1;
        load_seen_q <= 1'b1;
        if (&rd_addr_q || !pf_valid_q) err_q <= 1'b1;
      end
      if (wr_en)  wr_cnt_q <= wr_cnt_q + 1'b1;
      if (wr_ovf) err_q    <= 1'b1;
    end
  end

  // The word fetched for the previous load is still in flight on rd_data; bypass it
  // so back-to-back loads see fresh data with no bubble.
  assign bus.pe_data  = rd_pending_q ? bus.rd_data : pf_q;
  assign bus.pe_start = (state_q == S_RUN) && !load_seen_q;
  assign bus.busy     = (state_q == S_PREFETCH) || (state_q == S_ARM) || (state_q == S_RUN);
  assign bus.all_done = (state_q == S_DONE);
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_addr_q;
  assign wr_data      = wr_en ? bus.pe_res : '0;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_cnt_q[OUT_AW-1:0];
  assign bus.wr_data  = wr_data;
  assign bus.err      = err_q;

`ifdef STORE_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            checksum <= '0;
    else if (run_start) checksum <= '0;
    else if (wr_en)     checksum <= checksum ^ wr_data;
  end
`endif

endmodule
